// File: rtl/retro_catc_pkg.sv
// retro_catc_pkg: shared FSM state type and elaboration-time rate helpers
//   nco_inc   : phase increment = round(rf * 2^bits / core)
//   catch_div : minimum cycles between catch-up ticks = max(1, core / (factor * rf))
package retro_catc_pkg;
  typedef enum logic [1:0] {RUN, CATCHUP, STALL} state_e;
  function automatic longint unsigned nco_inc(longint unsigned core, longint unsigned rf, int unsigned bits);
    return ((rf << bits) + core / 2) / core;
  endfunction
  function automatic int unsigned catch_div(longint unsigned core, longint unsigned rf, longint unsigned factor);
    longint unsigned d;
    d = core / (factor * rf);
    return (d == 0) ? 32'd1 : 32'(d);
  endfunction
endpackage

// File: rtl/retro_catc_if.sv
// retro_catc_if: control/status bundle between the timing controller and its host
//   clk_en, stall, clear_overflow, channel_run : host -> controller
//   clk_en_out, master_tick, catching_up, debt, overflow : controller -> host
interface retro_catc_if #(
  parameter int Channels = 2,
  parameter int DebtBits = 16
);
  logic                clk_en;
  logic                stall;
  logic                clear_overflow;
  logic [Channels-1:0] channel_run;
  logic [Channels-1:0] clk_en_out;
  logic                master_tick;
  logic                catching_up;
  logic [DebtBits-1:0] debt;
  logic                overflow;
  modport master (
    output clk_en, stall, clear_overflow, channel_run,
    input  clk_en_out, master_tick, catching_up, debt, overflow
  );
  modport slave (
    input  clk_en, stall, clear_overflow, channel_run,
    output clk_en_out, master_tick, catching_up, debt, overflow
  );
endinterface

// File: rtl/retro_catc_chdiv.sv
// retro_catc_chdiv: per-channel master-tick divider producing one clock-enable
//   clk_i, rst_ni : clock, async active-low reset (counter loads Phase)
//   tick_i        : master tick (already gated by the global pause)
//   run_i         : output gate; the counter keeps running while gated
//   en_o          : clock-enable pulse on every Div-th master tick
module retro_catc_chdiv #(
  parameter int unsigned Div   = 1,
  parameter int unsigned Phase = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic run_i,
  output logic en_o
);
  localparam int unsigned W = Div > 1 ? $clog2(Div) : 1;
  localparam logic [W-1:0] Last = W'(Div - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = (cnt_q == Last) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= W'(Phase);
    else if (tick_i) cnt_q <= cnt_d;
  assign en_o = tick_i & run_i & (cnt_q == Last);
endmodule

// File: rtl/retro_catc_multi.sv
// retro_catc_multi: NCO reference tick with stall debt and catch-up, fanned out to channel dividers
//   clk_i, rst_ni : core clock, async active-low reset
//   bus (slave)   : pause/stall/overflow-clear/channel gates in; enables, master tick, debt status out
module retro_catc_multi
  import retro_catc_pkg::*;
#(
  parameter int unsigned     Channels       = 2,
  parameter longint unsigned CoreClock      = 200000000,
  parameter longint unsigned ReferenceClock = 21477272,
  parameter longint unsigned ClockFactor    = 2,
  parameter int unsigned     PhaseBits      = 32,
  parameter int unsigned     DebtBits       = 16,
  parameter int unsigned     ChannelDiv   [Channels] = '{12, 4},
  parameter int unsigned     ChannelPhase [Channels] = '{0, 0}
) (
  input logic clk_i,
  input logic rst_ni,
  retro_catc_if.slave bus
);
  localparam logic [PhaseBits-1:0] Inc = PhaseBits'(nco_inc(CoreClock, ReferenceClock, PhaseBits));
  localparam int unsigned CatchDiv = catch_div(CoreClock, ReferenceClock, ClockFactor);
  localparam int unsigned GapBits = CatchDiv > 1 ? $clog2(CatchDiv) : 1;
  localparam logic [GapBits-1:0] GapLoad = GapBits'(CatchDiv - 1);
  localparam logic [DebtBits-1:0] DebtMax = '1;

  state_e               state_q, state_d;
  logic [PhaseBits-1:0] acc_q, acc_d;
  logic                 ref_q, ref_d;
  logic [GapBits-1:0]   gap_q, gap_d;
  logic [DebtBits-1:0]  debt_q, debt_d;
  logic                 ovf_q, ovf_d;
  logic                 gap0, mt, up, dn, sat;
  logic [Channels-1:0]  en;

  // Carry-out of the phase accumulator is the drift-free reference tick.
  assign {ref_d, acc_d} = {1'b0, acc_q} + {1'b0, Inc};
  assign gap0 = gap_q == '0;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= RUN;
    else if (bus.clk_en) state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (up) state_d = bus.stall ? STALL : CATCHUP;
      CATCHUP: state_d = bus.stall ? STALL : (debt_d == '0 ? RUN : CATCHUP);
      STALL:   if (!bus.stall) state_d = (debt_d == '0) ? RUN : CATCHUP;
      default: state_d = RUN;
    endcase
  end

  // A reference tick that is not emitted becomes debt; an emitted tick
  // without a reference tick repays one. Both together cancel out.
  always_comb begin
    mt = 1'b0;
    if (bus.clk_en) mt = (state_q == RUN) ? ref_q & ~bus.stall & gap0 :
                         (state_q == CATCHUP) ? ~bus.stall & gap0 : 1'b0;
    up = ref_q & ~mt;
    dn = mt & ~ref_q;
    sat = up & (debt_q == DebtMax);
    debt_d = sat ? debt_q : up ? debt_q + 1'b1 : dn ? debt_q - 1'b1 : debt_q;
    ovf_d = ~bus.clear_overflow & (ovf_q | sat);
    gap_d = mt ? GapLoad : (gap0 ? gap_q : gap_q - 1'b1);
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      acc_q  <= '0;
      ref_q  <= 1'b0;
      gap_q  <= '0;
      debt_q <= '0;
      ovf_q  <= 1'b0;
    end else if (bus.clk_en) begin
      acc_q  <= acc_d;
      ref_q  <= ref_d;
      gap_q  <= gap_d;
      debt_q <= debt_d;
      ovf_q  <= ovf_d;
    end

  for (genvar c = 0; c < Channels; c++) begin : g_ch
    retro_catc_chdiv #(.Div(ChannelDiv[c]), .Phase(ChannelPhase[c])) u_div (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .tick_i (mt),
      .run_i  (bus.channel_run[c]),
      .en_o   (en[c])
    );
  end

  assign bus.clk_en_out  = en;
  assign bus.master_tick = mt;
  assign bus.catching_up = debt_q != '0;
  assign bus.debt        = debt_q;
  assign bus.overflow    = ovf_q;
endmodule
